// File: rtl/mfp_ahb_gpio_irq_slave.sv
// AHB-Lite GPIO slave: LED output register with set/clear aliases, synchronised switches,
// debounced pushbuttons and per-button edge interrupts with write-1-to-clear status.
module mfp_ahb_gpio_irq_slave #(
  parameter int N_SW      = 18,
  parameter int N_BTN     = 5,
  parameter int N_OUT     = 18,
  parameter int DB_PERIOD = 500000
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [31:0]       HADDR,
  input  logic [2:0]        HBURST,
  input  logic              HMASTLOCK,
  input  logic [3:0]        HPROT,
  input  logic [2:0]        HSIZE,
  input  logic              HSEL,
  input  logic [1:0]        HTRANS,
  input  logic [31:0]       HWDATA,
  input  logic              HWRITE,
  input  logic              SI_Endian,
  output logic [31:0]       HRDATA,
  output logic              HREADY,
  output logic              HRESP,
  input  logic [N_SW-1:0]   IO_Switches,
  input  logic [N_BTN-1:0]  IO_Buttons,
  output logic [N_OUT-1:0]  IO_Out,
  output logic              IO_IRQ
);

  localparam int CNT_W = $clog2(DB_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_PERIOD - 1);

  localparam logic [3:0] A_OUT      = 4'd0;
  localparam logic [3:0] A_OUT_SET  = 4'd1;
  localparam logic [3:0] A_OUT_CLR  = 4'd2;
  localparam logic [3:0] A_SW       = 4'd3;
  localparam logic [3:0] A_BTN      = 4'd4;
  localparam logic [3:0] A_IRQ_EN   = 4'd5;
  localparam logic [3:0] A_IRQ_STAT = 4'd6;
  localparam logic [3:0] A_IRQ_POL  = 4'd7;

  // captured address phase
  logic             vld_p1;
  logic             wr_p1;
  logic [3:0]       idx_p1;

  logic [N_OUT-1:0] out_reg;
  logic [N_BTN-1:0] en_reg;
  logic [N_BTN-1:0] stat_reg;
  logic [N_BTN-1:0] pol_reg;
  logic             irq_reg;

  logic [N_SW-1:0]  sw_p0;
  logic [N_SW-1:0]  sw_p1;
  logic [N_BTN-1:0] btn_p0;
  logic [N_BTN-1:0] btn_p1;

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [N_BTN-1:0] btn_smp;
  logic [N_BTN-1:0] btn_db;
  logic [N_BTN-1:0] btn_db_d;
  logic [N_BTN-1:0] btn_agree;
  logic [N_BTN-1:0] btn_edge;

  logic             wr_en;
  logic [N_BTN-1:0] w1c;
  logic [31:0]      rdata;

  // Burst, protection, size and endianness carry no meaning for this slave.
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:6], HADDR[1:0], HBURST, HMASTLOCK, HPROT, HSIZE,
                         SI_Endian, HTRANS[0], HWDATA};

  assign HREADY = 1'b1;
  assign HRESP  = 1'b0;
  assign IO_Out = out_reg;
  assign IO_IRQ = irq_reg;
  assign HRDATA = rdata;

  // ---- address phase -> data phase ----
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      vld_p1 <= 1'b0;
      wr_p1  <= 1'b0;
      idx_p1 <= 4'd0;
    end else begin
      vld_p1 <= HSEL & HTRANS[1];
      wr_p1  <= HWRITE;
      idx_p1 <= HADDR[5:2];
    end
  end

  assign wr_en = vld_p1 & wr_p1;
  assign w1c   = (wr_en && idx_p1 == A_IRQ_STAT) ? HWDATA[N_BTN-1:0] : '0;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      out_reg <= '0;
      en_reg  <= '0;
      pol_reg <= '0;
    end else if (wr_en) begin
      case (idx_p1)
        A_OUT:     out_reg <= HWDATA[N_OUT-1:0];
        A_OUT_SET: out_reg <= out_reg | HWDATA[N_OUT-1:0];
        A_OUT_CLR: out_reg <= out_reg & ~HWDATA[N_OUT-1:0];
        A_IRQ_EN:  en_reg  <= HWDATA[N_BTN-1:0];
        A_IRQ_POL: pol_reg <= HWDATA[N_BTN-1:0];
        default: ;
      endcase
    end
  end

  // ---- input synchronisers ----
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      sw_p0  <= '0;
      sw_p1  <= '0;
      btn_p0 <= '0;
      btn_p1 <= '0;
    end else begin
      sw_p0  <= IO_Switches;
      sw_p1  <= sw_p0;
      btn_p0 <= IO_Buttons;
      btn_p1 <= btn_p0;
    end
  end

  // ---- debounce sample tick ----
  assign tick = (tick_cnt == CNT_LAST);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // A bit only moves once two consecutive tick samples agree with the live value.
  assign btn_agree = ~(btn_smp ^ btn_p1);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      btn_smp  <= '0;
      btn_db   <= '0;
      btn_db_d <= '0;
    end else begin
      if (tick) begin
        btn_smp <= btn_p1;
        btn_db  <= (btn_db & ~btn_agree) | (btn_p1 & btn_agree);
      end
      btn_db_d <= btn_db;
    end
  end

  // ---- edge detect, status and interrupt ----
  // Polarity only selects which transition counts, so rewriting it cannot fabricate an edge.
  assign btn_edge = (btn_db & ~btn_db_d & ~pol_reg) | (~btn_db & btn_db_d & pol_reg);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      stat_reg <= '0;
      irq_reg  <= 1'b0;
    end else begin
      stat_reg <= (stat_reg & ~w1c) | btn_edge;
      irq_reg  <= |(stat_reg & en_reg);
    end
  end

  // ---- read mux ----
  always_comb begin
    rdata = '0;
    if (vld_p1 && !wr_p1) begin
      case (idx_p1)
        A_OUT:      rdata[N_OUT-1:0] = out_reg;
        A_SW:       rdata[N_SW-1:0]  = sw_p1;
        A_BTN:      rdata[N_BTN-1:0] = btn_db;
        A_IRQ_EN:   rdata[N_BTN-1:0] = en_reg;
        A_IRQ_STAT: rdata[N_BTN-1:0] = stat_reg;
        A_IRQ_POL:  rdata[N_BTN-1:0] = pol_reg;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mfp_ahb_gpio_irq_slave.md
MFP_AHB_GPIO_IRQ_SLAVE -- requirements
Module: mfp_ahb_gpio_irq_slave

Interface
REQ-001 Parameter N_SW, default 18, meaning switch input width (1..32).
REQ-002 Parameter N_BTN, default 5, meaning pushbutton input width (1..32).
REQ-003 Parameter N_OUT, default 18, meaning LED/output width (1..32).
REQ-004 Parameter DB_PERIOD, default 500000, meaning debounce sample-tick period in HCLK cycles (>=2).
REQ-005 Port HCLK, input, 1, meaning the single clock; all state SHALL change only on its rising edge.
REQ-006 Port HRESETn, input, 1, meaning reset; reset is synchronous and active-low.
REQ-007 Ports HADDR in 32, HBURST in 3, HMASTLOCK in 1, HPROT in 4, HSIZE in 3, HSEL in 1, HTRANS in 2, HWDATA in 32, HWRITE in 1, SI_Endian in 1, meaning standard AHB-Lite slave inputs; HBURST/HMASTLOCK/HPROT/HSIZE/SI_Endian SHALL be ignored.
REQ-008 Ports HRDATA out 32, HREADY out 1, HRESP out 1, meaning AHB-Lite slave outputs.
REQ-009 Port IO_Switches, input, N_SW, meaning asynchronous slide switches.
REQ-010 Port IO_Buttons, input, N_BTN, meaning asynchronous, bouncing pushbuttons.
REQ-011 Port IO_Out, output, N_OUT, meaning registered LED/output drive.
REQ-012 Port IO_IRQ, output, 1, meaning level interrupt request, active-high.

Function
REQ-013 HREADY SHALL be constant 1 (zero wait states); HRESP SHALL be constant 0.
REQ-014 Address phase SHALL be captured when HSEL=1 and HTRANS is NONSEQ or SEQ; IDLE/BUSY SHALL create no data phase.
REQ-015 Register select SHALL be word index HADDR[5:2]; writes use HWDATA in the following (data-phase) cycle; all writes treated as 32-bit.
REQ-016 HRDATA SHALL be combinational from the captured data-phase index, reflecting state after any write completed at the preceding edge; unused upper bits read 0; non-read or unmapped cycles return 0.
REQ-017 Map: 0 OUT (RW, N_OUT bits); 1 OUT_SET (W, ones set OUT bits, reads 0); 2 OUT_CLR (W, ones clear OUT bits, reads 0); 3 SW (RO, synchronised switches); 4 BTN (RO, debounced buttons); 5 IRQ_EN (RW, N_BTN bits); 6 IRQ_STAT (read; write-1-to-clear); 7 IRQ_POL (RW, bit=0 rising, 1 falling edge); 8..15 unmapped, writes ignored.
REQ-018 IO_Switches and IO_Buttons SHALL each pass a 2-flop synchroniser before any use.
REQ-019 A free-running counter SHALL pulse tick for one cycle every DB_PERIOD cycles, wrapping DB_PERIOD-1 -> 0.
REQ-020 On tick, per button: sample <= synced value; if sample equals synced value (two consecutive tick samples agree) debounced <= synced value; otherwise debounced holds.
REQ-021 Debounced edge detect: bit i edge SHALL be a one-cycle pulse when debounced[i] changes in the direction selected by IRQ_POL[i].
REQ-022 IRQ_STAT[i] SHALL set on edge[i] regardless of IRQ_EN[i]; cleared only by write of 1 to IRQ_STAT bit i.
REQ-023 Simultaneous edge[i] and W1C of bit i in same cycle: set SHALL win (bit reads 1).
REQ-024 IO_IRQ SHALL equal |(IRQ_STAT & IRQ_EN), registered one cycle after the state change.
REQ-025 Writing IRQ_POL SHALL not itself generate an edge or change IRQ_STAT.

Reset
REQ-026 While HRESETn=0 at a rising edge: OUT, IRQ_EN, IRQ_STAT, IRQ_POL, IO_IRQ, tick counter, synchronisers, samples, debounced values and captured address-phase state SHALL go to 0; IO_Out=0; HRDATA=0.
REQ-027 Reset asserted mid-transfer SHALL abort it; the pending write SHALL not take effect.
REQ-028 After reset release with buttons held high, debounce settling (0->1) SHALL set IRQ_STAT only if IRQ_POL bit is 0 (rising).

Verification
REQ-029 Write OUT=0x3FFFF, then OUT_CLR=0x0000F, then OUT_SET=0x10000 -> IO_Out 0x3FFFF, 0x3FFF0, 0x3FFF0; readbacks match; OUT_SET/OUT_CLR read 0.
REQ-030 DB_PERIOD=4, button0 bounces 0/1 every cycle for 20 cycles then holds 1 -> BTN bit0 stays 0 during bounce, becomes 1 within 2 ticks + 2 sync cycles of stable level, no earlier.
REQ-031 IRQ_EN=0x1, IRQ_POL=0, button0 debounced 0->1 -> IRQ_STAT=0x1, IO_IRQ=1 next cycle; write IRQ_STAT=0x1 -> IRQ_STAT=0, IO_IRQ=0.
REQ-032 Edge on bit0 coincident with W1C data phase of bit0 -> IRQ_STAT bit0 reads 1, IO_IRQ stays 1.
REQ-033 Back-to-back write OUT=0x5 then read OUT (adjacent NONSEQs) -> read returns 0x5; read of index 12 returns 0; IDLE write with HSEL=1 has no effect.
REQ-034 Assert HRESETn=0 during data phase of write OUT=0xFF -> IO_Out=0 after reset, OUT reads 0.
